// File: rtl/memShare_config_pkg.sv
// Shared constants and types for the memShare configuration path.
// Includes the IB-LUT preload state encoding and group load lengths.
package memShare_config_pkg;

  localparam int QUAN_SIZE_DEF = 4;
  localparam int GP1_COL_SEL_WIDTH_DEF = 2;
  localparam int GP2_COL_SEL_WIDTH_DEF = 4;

  localparam int GP1_VN_LOAD_CYCLE =
    2 ** (QUAN_SIZE_DEF + GP1_COL_SEL_WIDTH_DEF);
  localparam int GP2_VN_LOAD_CYCLE =
    2 ** (QUAN_SIZE_DEF + GP2_COL_SEL_WIDTH_DEF);

  typedef enum logic [1:0] {
    IB_PRELOAD_IDLE = 2'd0,
    IB_PRELOAD_GP1  = 2'd1,
    IB_PRELOAD_GP2  = 2'd2,
    IB_PRELOAD_DONE = 2'd3
  } ib_preload_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ib_colbank_preloader_if.sv
// Valid/ready stream of quantised IB-LUT entries.
// master drives entries, slave returns ready.
interface ib_colbank_preloader_if #(
  parameter int DW = 4
);
  logic [DW-1:0] src_data_i;
  logic          src_valid_i;
  logic          src_ready_o;

  modport master (
    output src_data_i,
    output src_valid_i,
    input  src_ready_o
  );

  modport slave (
    input  src_data_i,
    input  src_valid_i,
    output src_ready_o
  );
endinterface

// File: rtl/ib_preload_addr_cnt.sv
// Shared preload address counter with clear, enable and last flag.
// Clear has priority over enable; no wrap is relied on by callers.
module ib_preload_addr_cnt #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         is_last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_last_o = (cnt_q == last_i);

endmodule

// File: rtl/ib_colbank_preloader.sv
// IB-LUT preload engine for the GP1/GP2 column-bank IB-RAMs.
// One shared address counter is gated per group; writes are registered.
module ib_colbank_preloader
  import memShare_config_pkg::*;
#(
  parameter int QUAN_SIZE = QUAN_SIZE_DEF,
  parameter int GP1_COL_SEL_WIDTH = GP1_COL_SEL_WIDTH_DEF,
  parameter int GP2_COL_SEL_WIDTH = GP2_COL_SEL_WIDTH_DEF,
  localparam int GP1_RAM_ADDR_WIDTH = QUAN_SIZE + GP1_COL_SEL_WIDTH,
  localparam int GP2_RAM_ADDR_WIDTH = QUAN_SIZE + GP2_COL_SEL_WIDTH
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic load_start_i,
  input  logic [1:0] gp_mask_i,
  input  logic load_abort_i,
  ib_colbank_preloader_if.slave src,
  output logic gp1_we_o,
  output logic [GP1_RAM_ADDR_WIDTH-1:0] gp1_waddr_o,
  output logic [QUAN_SIZE-1:0] gp1_wdata_o,
  output logic gp2_we_o,
  output logic [GP2_RAM_ADDR_WIDTH-1:0] gp2_waddr_o,
  output logic [QUAN_SIZE-1:0] gp2_wdata_o,
  output logic busy_o,
  output logic done_o,
  output logic start_collision_o
);

  localparam int CW =
    max_w(GP1_RAM_ADDR_WIDTH, GP2_RAM_ADDR_WIDTH);

  localparam logic [1:0] S_IDLE = IB_PRELOAD_IDLE;
  localparam logic [1:0] S_GP1  = IB_PRELOAD_GP1;
  localparam logic [1:0] S_GP2  = IB_PRELOAD_GP2;
  localparam logic [1:0] S_DONE = IB_PRELOAD_DONE;

  localparam logic [CW-1:0] GP1_LAST =
    CW'((2 ** GP1_RAM_ADDR_WIDTH) - 1);
  localparam logic [CW-1:0] GP2_LAST =
    CW'((2 ** GP2_RAM_ADDR_WIDTH) - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] mask_q, mask_d;
  logic       gp1_we_q, gp1_we_d;
  logic       gp2_we_q, gp2_we_d;
  logic       coll_q, coll_d;

  logic [GP1_RAM_ADDR_WIDTH-1:0] gp1_waddr_q, gp1_waddr_d;
  logic [GP2_RAM_ADDR_WIDTH-1:0] gp2_waddr_q, gp2_waddr_d;
  logic [QUAN_SIZE-1:0] gp1_wdata_q, gp1_wdata_d;
  logic [QUAN_SIZE-1:0] gp2_wdata_q, gp2_wdata_d;

  logic          in_gp1, in_gp2, ready, accept;
  logic          cnt_clr, is_last;
  logic [CW-1:0] cnt, last_sel;

  assign in_gp1   = (state_q == S_GP1);
  assign in_gp2   = (state_q == S_GP2);
  assign ready    = in_gp1 | in_gp2;
  assign accept   = ready & src.src_valid_i;
  assign last_sel = in_gp1 ? GP1_LAST : GP2_LAST;
  assign cnt_clr  = (state_d != state_q);

  ib_preload_addr_cnt #(.W(CW)) u_cnt (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .clr_i     (cnt_clr),
    .en_i      (accept),
    .last_i    (last_sel),
    .cnt_o     (cnt),
    .is_last_o (is_last)
  );

  // Abort outranks a coinciding last beat.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          mask_d = gp_mask_i;
          if (gp_mask_i[0])      state_d = S_GP1;
          else if (gp_mask_i[1]) state_d = S_GP2;
          else                   state_d = S_DONE;
        end
      end
      S_GP1: begin
        if (load_abort_i)            state_d = S_IDLE;
        else if (accept && is_last)
          state_d = mask_q[1] ? S_GP2 : S_DONE;
      end
      S_GP2: begin
        if (load_abort_i)            state_d = S_IDLE;
        else if (accept && is_last)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gp1_we_d    = accept & in_gp1;
    gp2_we_d    = accept & in_gp2;
    gp1_waddr_d = gp1_waddr_q;
    gp1_wdata_d = gp1_wdata_q;
    gp2_waddr_d = gp2_waddr_q;
    gp2_wdata_d = gp2_wdata_q;
    if (gp1_we_d) begin
      gp1_waddr_d = cnt[GP1_RAM_ADDR_WIDTH-1:0];
      gp1_wdata_d = src.src_data_i;
    end
    if (gp2_we_d) begin
      gp2_waddr_d = cnt[GP2_RAM_ADDR_WIDTH-1:0];
      gp2_wdata_d = src.src_data_i;
    end
    coll_d = load_start_i & (state_q != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      gp1_we_q    <= 1'b0;
      gp2_we_q    <= 1'b0;
      gp1_waddr_q <= '0;
      gp2_waddr_q <= '0;
      gp1_wdata_q <= '0;
      gp2_wdata_q <= '0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      gp1_we_q    <= gp1_we_d;
      gp2_we_q    <= gp2_we_d;
      gp1_waddr_q <= gp1_waddr_d;
      gp2_waddr_q <= gp2_waddr_d;
      gp1_wdata_q <= gp1_wdata_d;
      gp2_wdata_q <= gp2_wdata_d;
      coll_q      <= coll_d;
    end
  end

  assign src.src_ready_o   = ready;
  assign gp1_we_o          = gp1_we_q;
  assign gp1_waddr_o       = gp1_waddr_q;
  assign gp1_wdata_o       = gp1_wdata_q;
  assign gp2_we_o          = gp2_we_q;
  assign gp2_waddr_o       = gp2_waddr_q;
  assign gp2_wdata_o       = gp2_wdata_q;
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign start_collision_o = coll_q;

endmodule

// File: tb/tb_ib_colbank_preloader.sv
// Scoreboard bench for ib_colbank_preloader.
// Driver pushes expected writes; a negedge monitor pops and compares.
module tb_ib_colbank_preloader;
  import memShare_config_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
    logic       done;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       load_start;
  logic [1:0] gp_mask;
  logic       load_abort;
  logic       gp1_we, gp2_we;
  logic [5:0] gp1_waddr;
  logic [7:0] gp2_waddr;
  logic [3:0] gp1_wdata, gp2_wdata;
  logic       busy, done, coll;

  ib_colbank_preloader_if #(.DW(4)) src_if ();

  ib_colbank_preloader dut (
    .sys_clk           (sys_clk),
    .rstn              (rstn),
    .load_start_i      (load_start),
    .gp_mask_i         (gp_mask),
    .load_abort_i      (load_abort),
    .src               (src_if.slave),
    .gp1_we_o          (gp1_we),
    .gp1_waddr_o       (gp1_waddr),
    .gp1_wdata_o       (gp1_wdata),
    .gp2_we_o          (gp2_we),
    .gp2_waddr_o       (gp2_waddr),
    .gp2_wdata_o       (gp2_wdata),
    .busy_o            (busy),
    .done_o            (done),
    .start_collision_o (coll)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   coll_cnt = 0;
  logic [7:0] l1a, l2a;
  logic [3:0] l1d, l2d;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m);
    load_start = 1'b1;
    gp_mask    = m;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input int grp, input int a, input logic dn);
    exp_t e;
    e.addr = 8'(a);
    e.data = 4'(a);
    e.done = dn;
    src_if.src_valid_i = 1'b1;
    src_if.src_data_i  = 4'(a);
    if (grp == 1) q1.push_back(e);
    else          q2.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    src_if.src_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic end_test(input string n, input int eb,
                          input int ed, input int ec);
    idle(3);
    if (eb >= 0) chk({n, "_busy_cycles"}, busy_cnt, eb);
    chk({n, "_done_count"}, done_cnt, ed);
    chk({n, "_collisions"}, coll_cnt, ec);
    chk({n, "_gp1_left"}, q1.size(), 0);
    chk({n, "_gp2_left"}, q2.size(), 0);
    busy_cnt = 0;
    done_cnt = 0;
    coll_cnt = 0;
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!rstn) begin
      l1a = '0; l1d = '0; l2a = '0; l2d = '0;
    end else begin
      if (gp1_we) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL gp1_unexpected: got addr %0h want none",
                   gp1_waddr);
        end else begin
          e = q1.pop_front();
          chk("gp1_waddr", 32'(gp1_waddr), 32'(e.addr));
          chk("gp1_wdata", 32'(gp1_wdata), 32'(e.data));
          chk("gp1_done", 32'(done), 32'(e.done));
          l1a = e.addr; l1d = e.data;
        end
      end else begin
        chk("gp1_hold_addr", 32'(gp1_waddr), 32'(l1a));
        chk("gp1_hold_data", 32'(gp1_wdata), 32'(l1d));
      end
      if (gp2_we) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL gp2_unexpected: got addr %0h want none",
                   gp2_waddr);
        end else begin
          e = q2.pop_front();
          chk("gp2_waddr", 32'(gp2_waddr), 32'(e.addr));
          chk("gp2_wdata", 32'(gp2_wdata), 32'(e.data));
          chk("gp2_done", 32'(done), 32'(e.done));
          l2a = e.addr; l2d = e.data;
        end
      end else begin
        chk("gp2_hold_addr", 32'(gp2_waddr), 32'(l2a));
        chk("gp2_hold_data", 32'(gp2_wdata), 32'(l2d));
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (coll) coll_cnt++;
    end
  end

  task automatic chk_all_zero(input string n);
    chk({n, "_ready"}, 32'(src_if.src_ready_o), 0);
    chk({n, "_gp1"}, {gp1_we, gp1_waddr, gp1_wdata}, 0);
    chk({n, "_gp2"}, {gp2_we, gp2_waddr, gp2_wdata}, 0);
    chk({n, "_status"}, {busy, done, coll}, 0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    load_start = 1'b0;
    gp_mask = 2'b00;
    load_abort = 1'b0;
    src_if.src_valid_i = 1'b0;
    src_if.src_data_i  = 4'h0;
    repeat (3) tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Both groups, continuous stream.
    start(2'b11);
    for (int b = 0; b < GP1_VN_LOAD_CYCLE; b++) send(1, b, 1'b0);
    for (int b = 0; b < GP2_VN_LOAD_CYCLE; b++)
      send(2, b, b == GP2_VN_LOAD_CYCLE - 1);
    end_test("mask11", 321, 1, 0);

    start(2'b10);
    for (int b = 0; b < GP2_VN_LOAD_CYCLE; b++)
      send(2, b, b == GP2_VN_LOAD_CYCLE - 1);
    end_test("mask10", 257, 1, 0);

    start(2'b00);
    end_test("mask00", 1, 1, 0);

    // Random stalls on a GP1-only load.
    start(2'b01);
    gp_mask = 2'b10;
    n = 0;
    while (n < GP1_VN_LOAD_CYCLE) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1, n, n == GP1_VN_LOAD_CYCLE - 1);
        n++;
      end else begin
        src_if.src_valid_i = 1'b0;
        src_if.src_data_i  = 4'($urandom);
        tick();
      end
    end
    end_test("stall", -1, 1, 0);

    // Abort coinciding with the GP2 beat at addr 99.
    start(2'b10);
    for (int b = 0; b < 100; b++) begin
      load_abort = (b == 99);
      send(2, b, 1'b0);
    end
    load_abort = 1'b0;
    idle(1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(src_if.src_ready_o), 0);
    end_test("abort", 100, 0, 0);
    start(2'b01);
    for (int b = 0; b < GP1_VN_LOAD_CYCLE; b++)
      send(1, b, b == GP1_VN_LOAD_CYCLE - 1);
    end_test("reload", 65, 1, 0);

    // Start collision and mask change mid-load.
    start(2'b01);
    for (int b = 0; b < GP1_VN_LOAD_CYCLE; b++) begin
      load_start = (b == 10);
      gp_mask    = 2'b11;
      send(1, b, b == GP1_VN_LOAD_CYCLE - 1);
    end
    load_start = 1'b0;
    end_test("collide", 65, 1, 1);

    // Reset during GP2 beat 50.
    start(2'b11);
    for (int b = 0; b < GP1_VN_LOAD_CYCLE; b++) send(1, b, 1'b0);
    for (int b = 0; b < 50; b++) send(2, b, 1'b0);
    rstn = 1'b0;
    src_if.src_valid_i = 1'b0;
    q1.delete();
    q2.delete();
    #2;
    chk_all_zero("midreset");
    tick();
    tick();
    rstn = 1'b1;
    src_if.src_valid_i = 1'b1;
    src_if.src_data_i  = 4'h5;
    repeat (5) tick();
    chk_all_zero("post_reset");
    busy_cnt = 0;
    done_cnt = 0;
    coll_cnt = 0;
    end_test("idle_after_reset", 0, 0, 0);
    start(2'b01);
    for (int b = 0; b < GP1_VN_LOAD_CYCLE; b++)
      send(1, b, b == GP1_VN_LOAD_CYCLE - 1);
    end_test("after_reset", 65, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ib_colbank_preloader.md
# ib_colbank_preloader

Parametrised IB-LUT preload engine for the column-bank IB-RAMs of share groups GP1 and GP2. It accepts a valid/ready stream of quantised IB-LUT entries and writes them into each group's RAM. Addresses are {column-bank select, row}. It supports per-group load masking, stalls, abort and completion signalling. It sits between the decoder configuration loader and the GP1/GP2 IB-RAM write ports, ahead of SCU.memShare() operation.

## Interface
Parameters:
- QUAN_SIZE, 4, row-address width and entry data width
- GP1_COL_SEL_WIDTH, 2, GP1 column-bank select width (GP1 banks = 2**GP1_COL_SEL_WIDTH)
- GP2_COL_SEL_WIDTH, 4, GP2 column-bank select width
- GP1_RAM_ADDR_WIDTH, QUAN_SIZE+GP1_COL_SEL_WIDTH, derived, not overridden
- GP2_RAM_ADDR_WIDTH, QUAN_SIZE+GP2_COL_SEL_WIDTH, derived, not overridden

Ports:
- sys_clk  in  1  single clock
- rstn  in  1  asynchronous, active-low reset
- load_start_i  in  1  start pulse, sampled in IDLE only
- gp_mask_i  in  2  bit0 = load GP1, bit1 = load GP2; sampled with load_start_i
- load_abort_i  in  1  abandon the current load
- src_data_i  in  QUAN_SIZE  entry data
- src_valid_i  in  1  entry valid
- src_ready_o  out  1  entry accepted when valid&&ready
- gp1_we_o / gp1_waddr_o / gp1_wdata_o  out  1 / GP1_RAM_ADDR_WIDTH / QUAN_SIZE  GP1 RAM write port
- gp2_we_o / gp2_waddr_o / gp2_wdata_o  out  1 / GP2_RAM_ADDR_WIDTH / QUAN_SIZE  GP2 RAM write port
- busy_o  out  1  high in LOAD_GP1, LOAD_GP2 and DONE
- done_o  out  1  one-cycle completion pulse
- start_collision_o  out  1  one-cycle pulse when load_start_i arrives outside IDLE

## Operation
- FSM states: IDLE, LOAD_GP1, LOAD_GP2, DONE.
- From IDLE, on load_start_i:
  - mask[0] set: go to LOAD_GP1.
  - otherwise, mask[1] set: go to LOAD_GP2.
  - mask 00: go to DONE.
- The mask is latched at start; changes to gp_mask_i during a load are ignored.
- A single address counter is cleared on entry to each LOAD state and increments by 1 per accepted beat.
  - The counter is the RAM address, so row (QUAN_SIZE bits) is the LSB field and column-bank select is the MSB field.
  - Group load length is 2**(QUAN_SIZE+COL_SEL_WIDTH) beats: 64 for GP1, 256 for GP2 at defaults.
- On the last beat (counter all-ones for that group):
  - LOAD_GP1 goes to LOAD_GP2 if latched mask[1] is set, else to DONE.
  - LOAD_GP2 goes to DONE.
  - There is no counter wrap; the state change occurs instead.
- DONE lasts exactly one cycle (done_o=1), then returns to IDLE.
- load_abort_i in either LOAD state:
  - Next state is IDLE; no done_o is produced.
  - A write already registered from the abort cycle's accepted beat still issues.
  - load_abort_i in IDLE or DONE is ignored.
- If load_abort_i and a last beat coincide, abort wins.
- load_start_i outside IDLE is ignored and pulses start_collision_o the next cycle.

## Timing
- Reset values of all outputs: 0. This includes src_ready_o, all we/waddr/wdata, busy_o, done_o and start_collision_o.
- Reset mid-load returns to IDLE immediately. Counters and the latched mask clear; no write is emitted after rstn deasserts.
- src_ready_o is a decode of the registered state: 1 in LOAD_GP1/LOAD_GP2, otherwise 0. It has no combinational path from src_valid_i.
- Write latency is 1 cycle: a beat accepted in cycle N gives gpX_we_o=1 in cycle N+1, with waddr equal to the counter value at N and wdata equal to src_data_i at N.
- Write outputs are registered. we is 0 in cycles without an accepted beat; waddr and wdata hold their last values.
- src_valid_i low stalls the load: the counter holds and no write is issued. There is no timeout.
- LOAD_GP1 to LOAD_GP2 is seamless: src_ready_o stays high, so beat 64 can be accepted in the cycle after GP1's last beat.
- done_o coincides with the final group's last write: cycle N+1 after last acceptance N.
- The first beat can be accepted 1 cycle after load_start_i. busy_o rises in that same cycle.

## Structure
- memShare_config_pkg gains:
  - typedef enum ib_preload_state_e {IB_PRELOAD_IDLE, IB_PRELOAD_GP1, IB_PRELOAD_GP2, IB_PRELOAD_DONE}
  - the derived constants GP1_VN_LOAD_CYCLE = 2**(QUAN_SIZE+GP1_COL_SEL_WIDTH) and GP2_VN_LOAD_CYCLE = 2**(QUAN_SIZE+GP2_COL_SEL_WIDTH); package defaults are the source of module parameter defaults.
- One sub-module: ib_preload_addr_cnt, a parametrised-width counter with clear, enable and an is_last flag. It is instantiated once, at the maximum of the two address widths, and gated per group.

## Test plan
- Mask 11, continuous valid, data = address LSBs → 64 GP1 writes at addr 0..63, then 256 GP2 writes at addr 0..255 with no bubble; done_o once, coincident with the GP2 addr 255 write; busy_o high for 321 cycles.
- Mask 10 → no gp1_we_o; GP2 addr 0..255 written; done_o after 256 beats.
- Mask 00 → busy_o for 1 cycle, done_o 1 cycle after start, no writes.
- Mask 01, src_valid_i toggling 1-0-1 randomly → exactly 64 GP1 writes in order 0..63, none duplicated; waddr and wdata hold during stalls.
- Abort at GP2 beat 100 (addr 99 accepted the same cycle) → write to addr 99 issues, then IDLE, no done_o; a following start with mask 01 reloads GP1 from addr 0.
- load_start_i at GP1 beat 10 → start_collision_o pulse, load unaffected. rstn low at GP2 beat 50 → all outputs 0, and after release the FSM idles until the next start.
